lc3_pipe_controller: RTL and testbench

Central sequencing controller for the group6 LC-3 pipelined datapath. It drives the stage enables, memory-state code, branch-taken flag and operand bypass selects, which are the signals carried on the controller_out interface.
- Inputs are the decode-stage instruction, the execute-stage instruction, PSR condition codes and the data-memory completion strobe.
- Pipeline start-up, memory-access stalls and post-branch flush/refill are all handled by one FSM.

---
 rtl/lc3_pipe_controller.sv | 186 ++++++++++++++++++
 tb/tb_lc3_pipe_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_pipe_controller.sv
// Central sequencing controller for the LC-3 pipelined datapath.
// One FSM covers pipeline warm-up (after reset or a control-op flush), steady-state
// running, and the memory-access stall states.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   IR, IR_Exec           instruction in decode / execute
//   psr                   current NZP condition codes
//   complete_data         data-memory access done this cycle
//   enable_*              registered stage enables
//   mem_state             registered memory code: 0 rd, 1 indirect rd, 2 wr, 3 idle
//   br_taken              combinational, valid only in RUN
//   bypass_{alu,mem}_{1,2} combinational operand forwarding selects, only in RUN
module lc3_pipe_controller #(
  parameter int unsigned WARMUP_STAGES = 4,
  parameter int unsigned IW            = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] IR,
  input  logic [IW-1:0] IR_Exec,
  input  logic [2:0]    psr,
  input  logic          complete_data,
  output logic          enable_updatePC,
  output logic          enable_fetch,
  output logic          enable_decode,
  output logic          enable_execute,
  output logic          enable_writeback,
  output logic [1:0]    mem_state,
  output logic          br_taken,
  output logic          bypass_alu_1,
  output logic          bypass_alu_2,
  output logic          bypass_mem_1,
  output logic          bypass_mem_2
);

  localparam logic [2:0] StWarmup = 3'd0;
  localparam logic [2:0] StRun    = 3'd1;
  localparam logic [2:0] StMemRd  = 3'd2;
  localparam logic [2:0] StMemInd = 3'd3;
  localparam logic [2:0] StMemWr  = 3'd4;

  localparam logic [1:0] MemRead  = 2'd0;
  localparam logic [1:0] MemInd   = 2'd1;
  localparam logic [1:0] MemWrite = 2'd2;
  localparam logic [1:0] MemIdle  = 2'd3;

  localparam logic [1:0] WcntLast = 2'(WARMUP_STAGES - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [4:0] en_q, en_d;     // {updatePC, fetch, decode, execute, writeback}
  logic [1:0] mem_q, mem_d;
  logic       ind_st_q, ind_st_d;  // indirect op is STI (else LDI)
  logic [2:0] ldr_q, ldr_d;        // destination of the last completed load
  logic       ldv_q, ldv_d;

  logic [3:0] op_ex, op_id;
  logic       ex_alu, ex_load, ex_ind, ex_store_dir, ex_store, ex_br, ex_jmp;
  logic       id_two_src, run;
  logic       unused_bits;

  assign op_ex = IR_Exec[IW-1 -: 4];
  assign op_id = IR[IW-1 -: 4];

  assign ex_alu       = op_ex inside {4'b0001, 4'b0101, 4'b1001, 4'b1110};
  assign ex_load      = op_ex inside {4'b0010, 4'b0110};
  assign ex_ind       = op_ex inside {4'b1010, 4'b1011};
  assign ex_store_dir = op_ex inside {4'b0011, 4'b0111};
  assign ex_store     = ex_store_dir | (op_ex == 4'b1011);
  assign ex_br        = (op_ex == 4'b0000);
  assign ex_jmp       = (op_ex == 4'b1100);
  // Only register-mode ADD/AND read a second source register.
  assign id_two_src   = ((op_id == 4'b0001) || (op_id == 4'b0101)) && !IR[5];

  assign unused_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    en_d     = en_q;
    mem_d    = mem_q;
    ind_st_d = ind_st_q;
    ldr_d    = ldr_q;
    ldv_d    = ldv_q;
    unique case (state_q)
      StWarmup: begin
        mem_d = MemIdle;
        en_d  = {2'b11, wcnt_q >= 2'd1, wcnt_q >= 2'd2, wcnt_q >= 2'd3};
        if (wcnt_q == WcntLast) begin
          state_d = StRun;
          wcnt_d  = 2'd0;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      StRun: begin
        en_d  = 5'h1f;
        mem_d = MemIdle;
        ldv_d = 1'b0;  // load-forwarding window is exactly one RUN cycle
        if (ex_load) begin
          state_d = StMemRd;
          en_d    = 5'h00;
          mem_d   = MemRead;
        end else if (ex_ind) begin
          state_d  = StMemInd;
          en_d     = 5'h00;
          mem_d    = MemInd;
          ind_st_d = op_ex[0];
        end else if (ex_store_dir) begin
          state_d = StMemWr;
          en_d    = 5'h00;
          mem_d   = MemWrite;
        end else if (ex_br || ex_jmp) begin
          // Flush regardless of outcome; the refill restarts from an idle cycle.
          state_d = StWarmup;
          wcnt_d  = 2'd0;
          en_d    = 5'h00;
        end
      end
      StMemInd: begin
        if (complete_data) begin
          state_d = ind_st_q ? StMemWr : StMemRd;
          mem_d   = ind_st_q ? MemWrite : MemRead;
        end
      end
      StMemRd: begin
        if (complete_data) begin
          state_d = StRun;
          en_d    = 5'h1f;
          mem_d   = MemIdle;
          ldr_d   = IR_Exec[11:9];
          ldv_d   = 1'b1;
        end
      end
      StMemWr: begin
        if (complete_data) begin
          state_d = StRun;
          en_d    = 5'h1f;
          mem_d   = MemIdle;
        end
      end
      default: begin
        state_d = StWarmup;
        wcnt_d  = 2'd0;
        en_d    = 5'h00;
        mem_d   = MemIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StWarmup;
      wcnt_q   <= 2'd0;
      en_q     <= 5'h00;
      mem_q    <= MemIdle;
      ind_st_q <= 1'b0;
      ldr_q    <= 3'd0;
      ldv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      en_q     <= en_d;
      mem_q    <= mem_d;
      ind_st_q <= ind_st_d;
      ldr_q    <= ldr_d;
      ldv_q    <= ldv_d;
    end
  end

  assign run = (state_q == StRun);

  assign {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback} = en_q;
  assign mem_state = mem_q;

  assign br_taken = run & (ex_br ? |(IR_Exec[11:9] & psr) : ex_jmp);

  assign bypass_alu_1 = run & ex_alu & (IR_Exec[11:9] == IR[8:6]);
  assign bypass_alu_2 = run & ex_alu & id_two_src & (IR_Exec[11:9] == IR[2:0]);
  // ALU forwarding wins; a store in execute never forwards.
  assign bypass_mem_1 = run & ldv_q & !ex_store & (ldr_q == IR[8:6]) & !bypass_alu_1;
  assign bypass_mem_2 = run & ldv_q & !ex_store & id_two_src & (ldr_q == IR[2:0]) &
                        !bypass_alu_2;

endmodule

// File: tb/tb_lc3_pipe_controller.sv
module tb_lc3_pipe_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] IR, IR_Exec;
  logic [2:0]  psr;
  logic        complete_data;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic [1:0]  mem_state;
  logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;

  lc3_pipe_controller #(.WARMUP_STAGES(4), .IW(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .psr              (psr),
    .complete_data    (complete_data),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .mem_state        (mem_state),
    .br_taken         (br_taken),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2),
    .bypass_mem_1     (bypass_mem_1),
    .bypass_mem_2     (bypass_mem_2)
  );

  always #5 clock = ~clock;

  // Scoreboard: expected {en[4:0], mem_state, br, alu1, alu2, mem1, mem2} per sample.
  logic [11:0] exp_q[$];
  int          tag_q[$];
  event        sample_ev;
  int          n_vec  = 0;
  int          n_fail = 0;
  int          n_push = 0;

  // Reference model: number of enabled stages (0, 2..5) plus a list of pending
  // memory phases for the instruction currently stalled in execute.
  int          m_stages;
  int          m_memq[$];
  logic [2:0]  m_ldr;
  bit          m_ldv;

  function automatic void model_reset();
    m_stages = 0;
    m_memq.delete();
    m_ldv = 1'b0;
    m_ldr = 3'd0;
  endfunction

  function automatic logic [11:0] model_out(logic [15:0] ir, logic [15:0] ex, logic [2:0] p);
    bit         running, ex_alu, ex_store, two;
    int         op, opi;
    logic [4:0] en;
    logic [1:0] ms;
    bit         br, a1, a2, m1, m2;
    int         mask;
    running  = (m_stages == 5) && (m_memq.size() == 0);
    op       = int'(ex[15:12]);
    opi      = int'(ir[15:12]);
    ex_alu   = (op == 1) || (op == 5) || (op == 9) || (op == 14);
    ex_store = (op == 3) || (op == 7) || (op == 11);
    two      = ((opi == 1) || (opi == 5)) && !ir[5];
    mask     = (32'h1f << (5 - m_stages)) & 32'h1f;
    en       = (m_memq.size() != 0) ? 5'd0 : mask[4:0];
    ms       = (m_memq.size() != 0) ? 2'(m_memq[0]) : 2'd3;
    br = 0; a1 = 0; a2 = 0; m1 = 0; m2 = 0;
    if (running) begin
      if (op == 0) br = |(ex[11:9] & p);
      else         br = (op == 12);
      a1 = ex_alu && (ex[11:9] == ir[8:6]);
      a2 = ex_alu && two && (ex[11:9] == ir[2:0]);
      m1 = m_ldv && !ex_store && (m_ldr == ir[8:6]) && !a1;
      m2 = m_ldv && !ex_store && two && (m_ldr == ir[2:0]) && !a2;
    end
    return {en, ms, br, a1, a2, m1, m2};
  endfunction

  function automatic void model_edge(logic [15:0] ex, logic cd);
    int op;
    int ph;
    op = int'(ex[15:12]);
    if (m_memq.size() != 0) begin
      if (cd) begin
        ph = m_memq.pop_front();
        if (ph == 0) begin
          m_ldr = ex[11:9];
          m_ldv = 1'b1;
        end
      end
    end else if (m_stages == 5) begin
      m_ldv = 1'b0;
      case (op)
        2, 6:   m_memq.push_back(0);
        10:     begin m_memq.push_back(1); m_memq.push_back(0); end
        11:     begin m_memq.push_back(1); m_memq.push_back(2); end
        3, 7:   m_memq.push_back(2);
        0, 12:  m_stages = 0;
        default: ;
      endcase
    end else begin
      m_stages = (m_stages == 0) ? 2 : m_stages + 1;
    end
  endfunction

  task automatic push_expected();
    exp_q.push_back(model_out(IR, IR_Exec, psr));
    tag_q.push_back(n_push);
    n_push++;
    -> sample_ev;
  endtask

  task automatic step(input logic [15:0] ir, input logic [15:0] ex, input logic [2:0] p,
                      input logic cd, input logic rst);
    @(negedge clock);
    IR = ir; IR_Exec = ex; psr = p; complete_data = cd; reset = rst;
    #1;
    if (rst) model_reset();
    push_expected();
    if (!rst) model_edge(ex, cd);
  endtask

  // Reset asserted mid-cycle must clear every output before the next edge.
  task automatic async_reset_check();
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    model_reset();
    push_expected();
  endtask

  function automatic logic [15:0] gen_instr(bit bias_alu);
    logic [31:0] r;
    logic [3:0]  op;
    r  = $urandom;
    op = r[3:0];
    if (bias_alu && r[4]) begin
      case (r[6:5])
        2'd0: op = 4'b0001;
        2'd1: op = 4'b0101;
        2'd2: op = 4'b1001;
        default: op = 4'b1110;
      endcase
    end
    return {op, 1'b0, r[8:7], 1'b0, r[10:9], r[11], r[13:12], 1'b0, r[15:14]};
  endfunction

  // Monitor: samples after each push, away from the rising edge.
  initial begin
    logic [11:0] act, expv;
    int          tag;
    forever begin
      @(sample_ev);
      #1;
      act = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
             mem_state, br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got %b, no expected entry", act);
      end else begin
        expv = exp_q.pop_front();
        tag  = tag_q.pop_front();
        n_vec++;
        if (act !== expv) begin
          n_fail++;
          $display("FAIL vec%0d {en,mem,br,alu1,alu2,mem1,mem2}: got %b_%b_%b_%b, want %b_%b_%b_%b",
                   tag, act[11:7], act[6:5], act[4], act[3:0],
                   expv[11:7], expv[6:5], expv[4], expv[3:0]);
        end
      end
    end
  end

  localparam logic [15:0] Nop = 16'h1000;

  initial begin
    logic [15:0] ir_r, ex_r;
    logic [31:0] r;
    reset = 1'b1; IR = Nop; IR_Exec = Nop; psr = 3'b000; complete_data = 1'b0;
    model_reset();

    // Reset, then warm-up ramp into RUN.
    step(Nop, Nop, 3'b010, 1'b0, 1'b1);
    step(Nop, Nop, 3'b010, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(Nop, Nop, 3'b010, 1'b0, 1'b0);

    // LDR R3 with completion two cycles late.
    step(Nop, 16'h6680, 3'b010, 1'b0, 1'b0);
    step(Nop, 16'h6680, 3'b010, 1'b0, 1'b0);
    step(Nop, 16'h6680, 3'b010, 1'b0, 1'b0);
    step(Nop, 16'h6680, 3'b010, 1'b1, 1'b0);
    step(Nop, Nop, 3'b010, 1'b0, 1'b0);

    // STI with immediate completions.
    for (int i = 0; i < 3; i++) step(Nop, 16'hB600, 3'b010, 1'b1, 1'b0);
    step(Nop, Nop, 3'b010, 1'b1, 1'b0);

    // BRz taken, then not taken; both flush.
    step(Nop, 16'h0405, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(Nop, Nop, 3'b010, 1'b0, 1'b0);
    step(Nop, 16'h0405, 3'b100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(Nop, Nop, 3'b100, 1'b0, 1'b0);

    // ALU forwarding, then load forwarding after LD R2.
    step(16'h1282, 16'h1481, 3'b000, 1'b0, 1'b0);
    step(16'h1282, 16'h2400, 3'b000, 1'b0, 1'b0);
    step(16'h1282, 16'h2400, 3'b000, 1'b1, 1'b0);
    step(16'h1282, Nop, 3'b000, 1'b0, 1'b0);
    step(16'h1282, Nop, 3'b000, 1'b0, 1'b0);

    // Store in execute while the load flag is live: no forwarding.
    step(16'h1282, 16'h2400, 3'b000, 1'b1, 1'b0);
    step(16'h1282, 16'h2400, 3'b000, 1'b1, 1'b0);
    step(16'h1282, 16'h3400, 3'b000, 1'b1, 1'b0);
    step(16'h1282, 16'h3400, 3'b000, 1'b1, 1'b0);
    step(16'h1282, Nop, 3'b000, 1'b0, 1'b0);

    // Asynchronous reset while stalled in a read.
    step(Nop, 16'h6680, 3'b000, 1'b0, 1'b0);
    step(Nop, 16'h6680, 3'b000, 1'b0, 1'b0);
    async_reset_check();
    step(Nop, 16'h6680, 3'b000, 1'b0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      r    = $urandom;
      ir_r = gen_instr(1'b0);
      ex_r = gen_instr(1'b1);
      if (r[7:0] == 8'd0) begin
        async_reset_check();
        step(ir_r, ex_r, r[10:8], r[11], 1'b1);
      end else begin
        step(ir_r, ex_r, r[10:8], r[11], 1'b0);
      end
    end

    @(negedge clock);
    @(negedge clock);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
